// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/freeze controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_W_DEF = 4;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   // ID/EX control fields; a bubble clears every one of them
   typedef struct packed {
      logic       wb_en;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       b;
      logic       s;
      logic [3:0] exe_cmd;
   } idex_ctrl_t;

   localparam idex_ctrl_t NOP_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// RAW / load-use detection at ID against the EXE and MEM destinations.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] i_src1,
   input  logic [REG_W-1:0] i_src2,
   input  logic             i_two_src,
   input  logic             i_id_valid,
   input  logic [REG_W-1:0] i_exe_dest,
   input  logic             i_exe_wb_en,
   input  logic             i_exe_mem_r_en,
   input  logic [REG_W-1:0] i_mem_dest,
   input  logic             i_mem_wb_en,
   input  logic             i_fwd_en,
   output logic             o_raw_c
);

   logic w_m1e;
   logic w_m2e;
   logic w_m1m;
   logic w_m2m;

   assign w_m1e = i_exe_wb_en & (i_src1 == i_exe_dest);
   assign w_m2e = i_two_src & i_exe_wb_en & (i_src2 == i_exe_dest);
   assign w_m1m = i_mem_wb_en & (i_src1 == i_mem_dest);
   assign w_m2m = i_two_src & i_mem_wb_en & (i_src2 == i_mem_dest);

   // With forwarding only a load in EXE cannot be bypassed in time
   assign o_raw_c = i_id_valid &
                    (i_fwd_en ? (i_exe_mem_r_en & (w_m1e | w_m2e))
                              : (w_m1e | w_m2e | w_m1m | w_m2m));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline control: hazard stall, branch flush, SRAM wait FSM with timeout,
// and saturating performance counters.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W   = REG_W_DEF,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic             id_valid,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             fwd_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             hazard,
   output logic             freeze_front,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             freeze_back,
   output logic             mem_start,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] hazard_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned      WAIT_W    = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_e             r_state;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic               r_mem_err;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_hazard_cnt;
   logic [CNT_W-1:0]   r_flush_cnt;

   logic w_raw;
   logic w_run_req;
   logic w_in_wait;
   logic w_timeout_hit;
   logic w_stall;
   logic w_hazard;
   logic w_flush_br;

   hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
      .i_src1         (src1),
      .i_src2         (src2),
      .i_two_src      (two_src),
      .i_id_valid     (id_valid),
      .i_exe_dest     (exe_dest),
      .i_exe_wb_en    (exe_wb_en),
      .i_exe_mem_r_en (exe_mem_r_en),
      .i_mem_dest     (mem_dest),
      .i_mem_wb_en    (mem_wb_en),
      .i_fwd_en       (fwd_en),
      .o_raw_c        (w_raw)
   );

   // Stall releases in the same cycle the SRAM answers or the wait expires
   assign w_run_req     = (r_state == ST_RUN) & mem_req;
   assign w_in_wait     = (r_state == ST_MEM_WAIT);
   assign w_timeout_hit = w_in_wait & ~mem_ready & (r_wait_cnt == WAIT_LAST);
   assign w_stall       = w_run_req | (w_in_wait & ~mem_ready & ~w_timeout_hit);
   assign w_hazard      = w_raw & ~branch_taken & ~w_stall;
   assign w_flush_br    = branch_taken & ~w_stall;

   assign hazard       = w_hazard;
   assign freeze_front = w_stall | w_hazard;
   assign flush_ifid   = w_flush_br;
   assign flush_idex   = (branch_taken | w_hazard) & ~w_stall;
   assign freeze_back  = w_stall;
   assign mem_start    = w_run_req;
   assign mem_err      = r_mem_err;
   assign stall_cnt    = r_stall_cnt;
   assign hazard_cnt   = r_hazard_cnt;
   assign flush_cnt    = r_flush_cnt;

   // Memory-access FSM with bounded wait
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (mem_req) begin
                  r_state    <= ST_MEM_WAIT;
                  r_wait_cnt <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ready) begin
                  r_state <= ST_RUN;
               end else if (w_timeout_hit) begin
                  r_state   <= ST_RUN;
                  r_mem_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt  <= '0;
         r_hazard_cnt <= '0;
         r_flush_cnt  <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != CNT_MAX))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_hazard && (r_hazard_cnt != CNT_MAX))
            r_hazard_cnt <= r_hazard_cnt + CNT_W'(1);
         if (w_flush_br && (r_flush_cnt != CNT_MAX))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

endmodule
